// File: rtl/encoder_speed_meter.sv
//------------------------------------------------------------------------------
// encoder_speed_meter
//
// Turns the single-cycle step/polarity pulses from the quadrature encoder
// reader into motor state for the speed/position control loop:
//   - a wrapping two's-complement position count,
//   - the direction of the last accepted step,
//   - the step period (clock cycles between the last two same-direction
//     steps), and
//   - a stall detector that declares the motor stopped after TIMEOUT_CYCLES
//     cycles without a step.
//
// Measurement FSM:
//   STOPPED : no reference step yet (after reset or after a stall)
//   ARMED   : one reference step seen, no valid period yet
//   RUNNING : at least one period has been measured in the current direction
//
// Parameters
//   POS_WIDTH       width of the position counter
//   PERIOD_WIDTH    width of the period counter and o_period
//   TIMEOUT_CYCLES  idle cycles before the motor is declared stopped;
//                   must be < 2**PERIOD_WIDTH
//
// Ports
//   i_clk           master clock
//   i_rst           synchronous reset, active-high
//   i_step          single-cycle step pulse
//   i_polarity      direction of the step: 1 = forward (+1), 0 = reverse (-1)
//   i_clear_pos     synchronous clear of the position
//   i_load_pos      synchronous load of the position from i_load_value
//   i_load_value    position preset value
//   o_position      signed position count
//   o_direction     direction of the last accepted step
//   o_period        cycles between the last two same-direction steps, 0 when
//                   stopped
//   o_period_valid  one-cycle pulse when o_period takes a new measurement
//   o_stopped       high while the FSM is in STOPPED
//   o_dir_change    one-cycle pulse when a step reverses the direction
//
// All outputs are registered: one cycle of latency from i_step.
//------------------------------------------------------------------------------
module encoder_speed_meter #(
   parameter int POS_WIDTH      = 32,
   parameter int PERIOD_WIDTH   = 24,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_step,
   input  logic                    i_polarity,
   input  logic                    i_clear_pos,
   input  logic                    i_load_pos,
   input  logic [POS_WIDTH-1:0]    i_load_value,
   output logic [POS_WIDTH-1:0]    o_position,
   output logic                    o_direction,
   output logic [PERIOD_WIDTH-1:0] o_period,
   output logic                    o_period_valid,
   output logic                    o_stopped,
   output logic                    o_dir_change
);

   localparam logic [PERIOD_WIDTH-1:0] C_TIMEOUT = PERIOD_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [PERIOD_WIDTH-1:0] C_ONE     = PERIOD_WIDTH'(1);
   localparam logic [PERIOD_WIDTH-1:0] C_ZERO    = '0;
   localparam logic [POS_WIDTH-1:0]    C_POS_ONE = POS_WIDTH'(1);

   typedef enum logic [1:0] {
      S_STOPPED = 2'd0,
      S_ARMED   = 2'd1,
      S_RUNNING = 2'd2
   } state_t;

   //---------------------------------------------------------------------------
   // Registers and their next-state values
   //---------------------------------------------------------------------------
   state_t                  r_state;
   state_t                  w_state_next;

   logic [PERIOD_WIDTH-1:0] r_count;
   logic [PERIOD_WIDTH-1:0] w_count_next;

   logic [PERIOD_WIDTH-1:0] r_period;
   logic [PERIOD_WIDTH-1:0] w_period_next;

   logic                    r_period_valid;
   logic                    w_period_valid_next;

   logic                    r_direction;
   logic                    w_direction_next;

   logic                    r_dir_change;
   logic                    w_dir_change_next;

   logic [POS_WIDTH-1:0]    r_position;

   //---------------------------------------------------------------------------
   // Shared decode
   //---------------------------------------------------------------------------
   logic w_active;     // ARMED or RUNNING: a reference step exists
   logic w_timeout;    // idle counter has reached the stall limit
   logic w_same_dir;   // incoming step agrees with the stored direction

   assign w_active   = (r_state != S_STOPPED);
   assign w_timeout  = (r_count == C_TIMEOUT);
   assign w_same_dir = (i_polarity == r_direction);

   //---------------------------------------------------------------------------
   // FSM process 1: state register
   //---------------------------------------------------------------------------
   // NOTE: clocked processes use non-blocking (<=) assignments so every
   // register samples the pre-edge value of every other register; blocking
   // assignments here would make the result depend on statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_STOPPED;
      end else begin
         r_state <= w_state_next;
      end
   end

   //---------------------------------------------------------------------------
   // FSM process 2: next-state logic
   //
   // A step always takes priority over the timeout, so a step arriving in
   // the very cycle the counter saturates is measured normally.
   //---------------------------------------------------------------------------
   // NOTE: every combinational output gets a default at the top of the block;
   // a path that leaves a signal unassigned would infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_STOPPED: begin
            if (i_step) begin
               w_state_next = S_ARMED;
            end
         end
         S_ARMED, S_RUNNING: begin
            if (i_step) begin
               // A reversal restarts measurement from a fresh reference.
               w_state_next = w_same_dir ? S_RUNNING : S_ARMED;
            end else if (w_timeout) begin
               w_state_next = S_STOPPED;
            end
         end
         default: begin
            w_state_next = S_STOPPED;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // FSM process 3: output / datapath next values
   //
   // The idle counter runs in every state. It restarts at 1 on a step so that
   // its value on the next step cycle equals the step-to-step distance, and
   // saturates at the timeout so it can never wrap into a bogus short period.
   //---------------------------------------------------------------------------
   always_comb begin
      w_count_next        = w_timeout ? r_count : (r_count + C_ONE);
      w_period_next       = r_period;
      w_period_valid_next = 1'b0;
      w_direction_next    = r_direction;
      w_dir_change_next   = 1'b0;

      if (i_step) begin
         w_count_next = C_ONE;
         if (!w_active) begin
            // First step after a stall only establishes the reference.
            w_direction_next = i_polarity;
         end else if (w_same_dir) begin
            w_period_next       = r_count;
            w_period_valid_next = 1'b1;
         end else begin
            // Reversal: the interval spans two directions and is not a
            // meaningful speed sample, so it is discarded.
            w_dir_change_next = 1'b1;
            w_direction_next  = i_polarity;
         end
      end else if (w_active && w_timeout) begin
         w_count_next  = C_ZERO;
         w_period_next = C_ZERO;
      end
   end

   //---------------------------------------------------------------------------
   // Output / datapath registers
   //---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count        <= C_ZERO;
         r_period       <= C_ZERO;
         r_period_valid <= 1'b0;
         r_direction    <= 1'b0;
         r_dir_change   <= 1'b0;
      end else begin
         r_count        <= w_count_next;
         r_period       <= w_period_next;
         r_period_valid <= w_period_valid_next;
         r_direction    <= w_direction_next;
         r_dir_change   <= w_dir_change_next;
      end
   end

   //---------------------------------------------------------------------------
   // Position counter
   //
   // Priority: reset > load > clear > step. A step that collides with a load
   // or clear is dropped from the position only; the FSM above still sees it.
   // The count wraps modulo 2**POS_WIDTH.
   //---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_position <= '0;
      end else if (i_load_pos) begin
         r_position <= i_load_value;
      end else if (i_clear_pos) begin
         r_position <= '0;
      end else if (i_step) begin
         if (i_polarity) begin
            r_position <= r_position + C_POS_ONE;
         end else begin
            r_position <= r_position - C_POS_ONE;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign o_position     = r_position;
   assign o_direction    = r_direction;
   assign o_period       = r_period;
   assign o_period_valid = r_period_valid;
   assign o_dir_change   = r_dir_change;
   // Decoded straight from the state register, so it is still a registered
   // output and is high exactly while the FSM is in STOPPED.
   assign o_stopped      = (r_state == S_STOPPED);

endmodule

// File: tb/tb_encoder_speed_meter.sv
//------------------------------------------------------------------------------
// Testbench for encoder_speed_meter (TIMEOUT_CYCLES = 50).
//
// Every cycle the DUT outputs are compared with a reference model that works
// on step timestamps (period = edge index difference, stall = 50 edges since
// the last step). A fixed vector table, several directed sequences and a
// randomized run all drive stimulus through the same per-cycle task.
//------------------------------------------------------------------------------
module tb_encoder_speed_meter;

   localparam int PW = 32;
   localparam int DW = 24;
   localparam int TO = 50;

   logic          clk = 1'b0;
   logic          i_rst = 1'b0;
   logic          i_step = 1'b0;
   logic          i_polarity = 1'b0;
   logic          i_clear_pos = 1'b0;
   logic          i_load_pos = 1'b0;
   logic [PW-1:0] i_load_value = '0;
   logic [PW-1:0] o_position;
   logic          o_direction;
   logic [DW-1:0] o_period;
   logic          o_period_valid;
   logic          o_stopped;
   logic          o_dir_change;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   encoder_speed_meter #(
      .POS_WIDTH      (PW),
      .PERIOD_WIDTH   (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_step         (i_step),
      .i_polarity     (i_polarity),
      .i_clear_pos    (i_clear_pos),
      .i_load_pos     (i_load_pos),
      .i_load_value   (i_load_value),
      .o_position     (o_position),
      .o_direction    (o_direction),
      .o_period       (o_period),
      .o_period_valid (o_period_valid),
      .o_stopped      (o_stopped),
      .o_dir_change   (o_dir_change)
   );

   //---------------------------------------------------------------------------
   // Reference model: timestamp based
   //---------------------------------------------------------------------------
   logic [PW-1:0] m_pos = '0;
   logic [DW-1:0] m_per = '0;
   bit            m_dir, m_valid, m_dchg;
   bit            m_stopped = 1'b1;
   longint        m_edge = 0;
   longint        m_last = 0;

   task automatic model(input bit step, pol, clr, ld, input logic [PW-1:0] val, input bit rst);
      m_edge++;
      if (rst) begin
         m_pos = '0; m_per = '0; m_dir = 0; m_valid = 0; m_dchg = 0; m_stopped = 1;
      end else begin
         m_valid = 0;
         m_dchg  = 0;
         if (ld)        m_pos = val;
         else if (clr)  m_pos = '0;
         else if (step) m_pos = pol ? m_pos + 1 : m_pos - 1;
         if (step) begin
            if (m_stopped) begin
               m_stopped = 0;
               m_dir     = pol;
            end else if (pol == m_dir) begin
               m_per   = DW'(m_edge - m_last);
               m_valid = 1;
            end else begin
               m_dchg = 1;
               m_dir  = pol;
            end
            m_last = m_edge;
         end else if (!m_stopped && (m_edge - m_last == longint'(TO))) begin
            m_stopped = 1;
            m_per     = '0;
         end
      end
   endtask

   function automatic logic [63:0] pack(logic [PW-1:0] pos, logic [DW-1:0] per,
                                        logic dir, logic v, logic st, logic dc);
      return {4'h0, pos, per, dir, v, st, dc};
   endfunction

   function automatic logic [63:0] dut_vec();
      return pack(o_position, o_period, o_direction, o_period_valid, o_stopped, o_dir_change);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock: drive inputs at negedge, model the edge, sample #1 after it.
   task automatic tick(input bit step, pol, clr, ld, input logic [PW-1:0] val, input bit rst);
      @(negedge clk);
      i_step = step; i_polarity = pol; i_clear_pos = clr;
      i_load_pos = ld; i_load_value = val; i_rst = rst;
      @(posedge clk);
      model(step, pol, clr, ld, val, rst);
      #1;
      check("model", dut_vec(), pack(m_pos, m_per, m_dir, m_valid, m_stopped, m_dchg));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(0, 0, 0, 0, '0, 0);
   endtask

   //---------------------------------------------------------------------------
   // Vector table
   //---------------------------------------------------------------------------
   typedef struct {
      bit            step, pol, clr, ld, rst;
      logic [PW-1:0] val;
      logic [PW-1:0] pos;
      logic [DW-1:0] per;
      bit            dir, v, st, dc;
   } vec_t;

   vec_t vec [14];

   initial begin
      int pulses;
      //          step pol clr ld rst  val            pos           per dir v st dc
      vec[0]  = '{0, 0, 0, 0, 1, 32'd0,    32'd0,        24'd0, 0, 0, 1, 0};
      vec[1]  = '{1, 1, 0, 0, 0, 32'd0,    32'd1,        24'd0, 1, 0, 0, 0};
      vec[2]  = '{0, 0, 0, 0, 0, 32'd0,    32'd1,        24'd0, 1, 0, 0, 0};
      vec[3]  = '{0, 0, 0, 0, 0, 32'd0,    32'd1,        24'd0, 1, 0, 0, 0};
      vec[4]  = '{1, 1, 0, 0, 0, 32'd0,    32'd2,        24'd3, 1, 1, 0, 0};
      vec[5]  = '{1, 1, 0, 0, 0, 32'd0,    32'd3,        24'd1, 1, 1, 0, 0};
      vec[6]  = '{1, 0, 0, 0, 0, 32'd0,    32'd2,        24'd1, 0, 0, 0, 1};
      vec[7]  = '{1, 0, 0, 0, 0, 32'd0,    32'd1,        24'd1, 0, 1, 0, 0};
      vec[8]  = '{1, 1, 0, 1, 0, 32'd1000, 32'd1000,     24'd1, 1, 0, 0, 1};
      vec[9]  = '{1, 1, 1, 0, 0, 32'd0,    32'd0,        24'd1, 1, 1, 0, 0};
      vec[10] = '{0, 0, 0, 0, 0, 32'd0,    32'd0,        24'd1, 1, 0, 0, 0};
      vec[11] = '{1, 0, 0, 0, 0, 32'd0,    32'hFFFFFFFF, 24'd1, 0, 0, 0, 1};
      vec[12] = '{1, 1, 0, 0, 0, 32'd0,    32'd0,        24'd1, 1, 0, 0, 1};
      vec[13] = '{1, 1, 0, 0, 1, 32'd0,    32'd0,        24'd0, 0, 0, 1, 0};

      for (int i = 0; i < 14; i++) begin
         tick(vec[i].step, vec[i].pol, vec[i].clr, vec[i].ld, vec[i].val, vec[i].rst);
         check($sformatf("vec%0d", i), dut_vec(),
               pack(vec[i].pos, vec[i].per, vec[i].dir, vec[i].v, vec[i].st, vec[i].dc));
      end

      // Five forward steps spaced 10 cycles: four periods of 10.
      tick(0, 0, 0, 0, '0, 1);
      pulses = 0;
      for (int s = 0; s < 5; s++) begin
         tick(1, 1, 0, 0, '0, 0);
         if (s == 0) check("stopped_falls", 64'(o_stopped), 64'd0);
         if (o_period_valid) begin
            pulses++;
            check("period10", 64'(o_period), 64'd10);
         end
         idle(9);
      end
      check("pulses4", 64'(pulses), 64'd4);
      check("pos5", 64'(o_position), 64'd5);
      check("dir1", 64'(o_direction), 64'd1);

      // Forward at t, reverse at t+7, reverse at t+20.
      tick(0, 0, 0, 0, '0, 1);
      tick(1, 1, 0, 0, '0, 0);
      idle(6);
      tick(1, 0, 0, 0, '0, 0);
      check("dchg_pulse", {62'd0, o_dir_change, o_period_valid}, 64'b10);
      idle(12);
      tick(1, 0, 0, 0, '0, 0);
      check("period13", {39'd0, o_period_valid, o_period}, {39'd0, 1'b1, 24'd13});
      check("pos_m1", 64'(o_position), 64'hFFFFFFFF);

      // Timeout: period 10 then idle; stop exactly 51 cycles after last step.
      tick(0, 0, 0, 0, '0, 1);
      tick(1, 1, 0, 0, '0, 0);
      idle(9);
      tick(1, 1, 0, 0, '0, 0);
      check("pre_to_period", 64'(o_period), 64'd10);
      idle(49);
      check("not_yet_stopped", 64'(o_stopped), 64'd0);
      idle(1);
      check("stopped_to", {39'd0, o_stopped, o_period}, {39'd0, 1'b1, 24'd0});
      tick(1, 1, 0, 0, '0, 0);
      check("armed_no_valid", {62'd0, o_period_valid, o_stopped}, 64'd0);

      // Step coinciding with the timeout wins.
      idle(49);
      tick(1, 1, 0, 0, '0, 0);
      check("step_wins_to", {38'd0, o_stopped, o_period_valid, o_period}, {38'd0, 1'b0, 1'b1, 24'd50});

      // Wrap both ways via load.
      tick(0, 0, 0, 1, 32'hFFFFFFFF, 0);
      tick(1, 1, 0, 0, '0, 0);
      check("wrap_up", 64'(o_position), 64'd0);
      tick(1, 0, 0, 0, '0, 0);
      check("wrap_down", 64'(o_position), 64'hFFFFFFFF);

      // Load 1000 with a same-direction step: load wins, period still measured.
      tick(1, 0, 0, 0, '0, 0);
      tick(1, 1, 0, 0, '0, 0);
      idle(3);
      tick(1, 1, 0, 1, 32'd1000, 0);
      check("load_step", {7'd0, o_period_valid, o_period, o_position},
            {7'd0, 1'b1, 24'd4, 32'd1000});

      // Back-to-back steps then reset mid-stream.
      for (int s = 0; s < 4; s++) begin
         tick(1, 1, 0, 0, '0, 0);
         check("b2b_period1", {39'd0, o_period_valid, o_period}, {39'd0, 1'b1, 24'd1});
      end
      tick(1, 1, 0, 0, '0, 1);
      check("rst_mid", dut_vec(), pack('0, '0, 0, 0, 1, 0));

      // Randomized run with phases of differing step density.
      for (int ph = 0; ph < 8; ph++) begin
         int unsigned div;
         case (ph % 4)
            0: div = 2;
            1: div = 8;
            2: div = 40;
            default: div = 120;
         endcase
         for (int c = 0; c < 600; c++) begin
            bit st, pl, cl, ld, rs;
            st = ($urandom_range(div - 1) == 0);
            pl = ($urandom_range(9) != 0) ? m_dir : ~m_dir;
            if (m_stopped) pl = 1'($urandom_range(1));
            cl = ($urandom_range(99) == 0);
            ld = ($urandom_range(99) == 0);
            rs = ($urandom_range(299) == 0);
            tick(st, pl, cl, ld, $urandom, rs);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/encoder_speed_meter.md
# encoder_speed_meter

Consumes the single-cycle step/polarity pulses produced by the quadrature encoder reader and turns them into motor state: a signed wrapping position count, the current direction, and the measured step period in clock cycles. It sits directly downstream of the encoder reader and feeds the motor speed/position control loop. A timeout detects a stalled motor and invalidates the speed measurement.

## Interface
- POS_WIDTH, 32, width of position counter (two's complement)
- PERIOD_WIDTH, 24, width of period counter/output
- TIMEOUT_CYCLES, 1_000_000, cycles without a step before motor is declared stopped; must be < 2^PERIOD_WIDTH
- i_clk  in  1  master clock
- i_rst  in  1  synchronous reset, active-high
- i_step  in  1  single-cycle step pulse from encoder reader
- i_polarity  in  1  direction of the step in the same cycle: 1 = forward (+1), 0 = reverse (−1)
- i_clear_pos  in  1  synchronous clear of position
- i_load_pos  in  1  synchronous load of position from i_load_value
- i_load_value  in  POS_WIDTH  position preset value
- o_position  out  POS_WIDTH  signed position count
- o_direction  out  1  direction of last accepted step
- o_period  out  PERIOD_WIDTH  clock cycles between the last two same-direction steps; 0 when stopped
- o_period_valid  out  1  one-cycle pulse when o_period is updated with a new measurement
- o_stopped  out  1  high while in STOPPED state
- o_dir_change  out  1  one-cycle pulse when a step reverses direction

## Operation
- Reset values: o_position 0, o_direction 0, o_period 0, o_period_valid 0, o_stopped 1, o_dir_change 0, state STOPPED, period counter 0.
- Position: on i_step, +1 if i_polarity=1 else −1; wraps modulo 2^POS_WIDTH (no saturation).
- Position priority: i_rst > i_load_pos > i_clear_pos > i_step. A step coinciding with load/clear is dropped from the position, but still processed by the period FSM and direction logic.
- Period counter: set to 1 on a step cycle; incremented by 1 on every non-step cycle; saturates at TIMEOUT_CYCLES.
- FSM states: STOPPED, ARMED (one reference step seen, no valid period yet), RUNNING.
- STOPPED: step → ARMED, o_direction ← i_polarity, counter ← 1, no period output, no o_dir_change.
- ARMED/RUNNING, step with i_polarity == o_direction: o_period ← counter, o_period_valid pulse, counter ← 1, → RUNNING.
- ARMED/RUNNING, step with i_polarity != o_direction: o_dir_change pulse, o_direction ← i_polarity, counter ← 1, no period output, → ARMED.
- ARMED/RUNNING, no step and counter == TIMEOUT_CYCLES: → STOPPED, o_period ← 0, counter ← 0.
- A step in the same cycle as the timeout condition wins: handled as a normal step, no transition to STOPPED.
- o_stopped is 1 exactly when state is STOPPED.
- i_rst mid-operation: all outputs and state return to reset values on the next edge; pending measurement discarded.

## Timing
- All outputs registered; latency 1 cycle from i_step to o_position/o_direction/o_period/pulses.
- Steps at cycles t0 and t1 (same direction, t1 > t0) give o_period = t1 − t0, visible at t1+1 with o_period_valid high for exactly that cycle.
- Back-to-back steps (consecutive cycles) give o_period = 1.
- Timeout: last step at t0, no further step → o_stopped rises at t0 + TIMEOUT_CYCLES + 1.
- o_period holds its value between updates; only changes on a valid measurement or on entering STOPPED.

## Test plan
- Reset, then 5 forward steps spaced 10 cycles → o_position = 5, o_direction = 1, o_stopped falls 1 cycle after first step, four o_period_valid pulses each with o_period = 10.
- Forward step at t, reverse step at t+7, reverse step at t+20 → o_dir_change pulse at t+8, no period at t+8, o_period = 13 with valid at t+21, o_position = −1.
- TIMEOUT_CYCLES = 50, single step then idle → o_stopped = 1 at step+51, o_period = 0; next step gives no period pulse (ARMED).
- Position at 2^POS_WIDTH−1 plus one forward step → o_position = 0; at 0 one reverse step → all-ones.
- i_load_pos with i_load_value = 1000 coinciding with a forward step → o_position = 1000, period measurement still updated.
- Steps on consecutive cycles → o_period = 1 each; i_rst asserted mid-stream → all outputs at reset values next cycle, o_stopped = 1.
